// File: rtl/spi_frame_pkg.sv
// Shared state type and sizing helpers for the SPI frame sequencer.
package spi_frame_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_DONE
    } state_t;

    localparam int ADDR_W_DFLT = 7;
    localparam int DATA_W_DFLT = 8;

    // R/W is the first bit shifted in, so it lands above the address
    function automatic int hdr_rw_pos(input int addr_w);
        return addr_w;
    endfunction

    function automatic int cnt_width(input int addr_w, input int data_w);
        return $clog2(1 + addr_w + data_w + 1);
    endfunction
endpackage

// File: rtl/spi_edge_sync.sv
// SCLK / CS_N edge history in the system clock domain; history holds while ena is low.
module spi_edge_sync (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic sclk,
    input  logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall
);
    logic sclk_q, sclk_d;
    logic cs_q, cs_d;

    always_comb begin
        sclk_d = ena ? sclk : sclk_q;
        cs_d   = ena ? cs_n : cs_q;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            sclk_q <= sclk_d;
            cs_q   <= cs_d;
        end
    end

    assign sclk_rise = ena & sclk & ~sclk_q;
    assign sclk_fall = ena & ~sclk & sclk_q;
    assign cs_fall   = ena & ~cs_n & cs_q;
endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 peripheral frame sequencer: header + data deserialize, register write
// strobe or req/ack read with MISO serialization, abort on early CS_N release.
//
//   state      | meaning
//   ST_IDLE    | waiting for cs_n to fall
//   ST_HDR     | shifting in R/W + address
//   ST_RD_WAIT | reg_rd_req held, waiting for ack
//   ST_RD_DATA | serializing read data on miso
//   ST_WR_DATA | shifting in write data
//   ST_DONE    | frame complete, waiting for cs_n high
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_rd_req,
    input  logic              reg_rd_ack,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy,
    output logic              err_abort,
    output logic              err_late
);
    localparam int CNT_W  = cnt_width(ADDR_W, DATA_W);
    localparam int RW_POS = hdr_rw_pos(ADDR_W);
    localparam int SH_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              rd_req_q, rd_req_d;
    logic              err_abort_q, err_abort_d;
    logic              err_late_q, err_late_d;
    logic              sclk_rise, sclk_fall, cs_fall;
    logic              in_frame;
    logic [ADDR_W:0]   hdr;

    spi_edge_sync u_edge (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall)
    );

    assign in_frame = (state_q == ST_HDR) || (state_q == ST_RD_WAIT) ||
                      (state_q == ST_RD_DATA) || (state_q == ST_WR_DATA);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        rd_req_d    = rd_req_q;
        err_abort_d = 1'b0;
        err_late_d  = 1'b0;
        hdr         = {sh_q[ADDR_W-1:0], mosi};

        if (ena) begin
            if (in_frame && cs_n) begin
                state_d     = ST_IDLE;
                rd_req_d    = 1'b0;
                err_abort_d = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_d = ST_HDR;
                            cnt_d   = '0;
                            sh_d    = '0;
                        end
                    end
                    ST_HDR: begin
                        if (sclk_rise) begin
                            sh_d  = {sh_q[SH_W-2:0], mosi};
                            cnt_d = cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(ADDR_W)) begin
                                reg_addr_d = hdr[ADDR_W-1:0];
                                cnt_d      = '0;
                                sh_d       = '0;
                                if (hdr[RW_POS]) begin
                                    state_d  = ST_RD_WAIT;
                                    rd_req_d = 1'b1;
                                end else begin
                                    state_d = ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_RD_WAIT: begin
                        // a rise coinciding with ack has already consumed bit 0
                        if (reg_rd_ack) begin
                            tx_d     = reg_rd_data;
                            rd_req_d = 1'b0;
                            state_d  = ST_RD_DATA;
                            cnt_d    = sclk_rise ? CNT_W'(1) : '0;
                        end else if (sclk_rise) begin
                            err_late_d = 1'b1;
                            tx_d       = '0;
                            rd_req_d   = 1'b0;
                            state_d    = ST_RD_DATA;
                            cnt_d      = CNT_W'(1);
                        end
                    end
                    ST_RD_DATA: begin
                        // the header's trailing fall must not shift away the MSB
                        if (sclk_rise) begin
                            cnt_d = cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                                state_d = ST_DONE;
                            end
                        end else if (sclk_fall && (cnt_q != '0)) begin
                            tx_d = {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    ST_WR_DATA: begin
                        if (sclk_rise) begin
                            sh_d  = {sh_q[SH_W-2:0], mosi};
                            cnt_d = cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                                reg_wdata_d = {sh_q[DATA_W-2:0], mosi};
                                reg_we_d    = 1'b1;
                                state_d     = ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (cs_n) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            err_abort_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            rd_req_q    <= rd_req_d;
            err_abort_q <= err_abort_d;
            err_late_q  <= err_late_d;
        end
    end

    assign miso       = (state_q == ST_RD_DATA) ? tx_q[DATA_W-1] : 1'b0;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_we     = reg_we_q;
    assign reg_rd_req = rd_req_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_abort  = err_abort_q;
    assign err_late   = err_late_q;
endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

SPI mode-0 peripheral frame sequencer sitting between the synchronized SPI pins and the register bank. It detects SCLK and CS_N edges in the system clock domain, deserializes a header (R/W + address) and data word, and issues single-cycle register writes or a req/ack register read whose data it serializes back on MISO. It also aborts cleanly on premature CS_N deassertion.

## Interface
Parameters:
- ADDR_W, 7, register address width; header = 1 R/W bit + ADDR_W bits, MSB first
- DATA_W, 8, register data width

Ports:
- clk  in  1  system clock
- rstb  in  1  reset, synchronous, active-low
- ena  in  1  clock enable; when low, edge history, state, counters and shift registers hold
- sclk  in  1  SPI clock, already synchronized to clk, idles low
- cs_n  in  1  SPI chip select, already synchronized, active-low
- mosi  in  1  SPI data in, already synchronized
- miso  out  1  SPI data out
- reg_addr  out  ADDR_W  captured address, stable from end of header until next frame start
- reg_wdata  out  DATA_W  captured write data
- reg_we  out  1  one-cycle write strobe
- reg_rd_req  out  1  read request, level, held until ack
- reg_rd_ack  in  1  read acknowledge; reg_rd_data is valid in the same cycle
- reg_rd_data  in  DATA_W  read data
- busy  out  1  high while state is not IDLE
- err_abort  out  1  one-cycle pulse: cs_n rose mid-frame
- err_late  out  1  one-cycle pulse: first read-data rising SCLK edge seen before ack

## Operation
- Edge detection: sclk_q, cs_q registered when ena; rise = sclk & !sclk_q, fall = !sclk & sclk_q, all qualified by ena. sclk_q resets to 0, cs_q resets to 1.
- States: IDLE, HDR, RD_WAIT, RD_DATA, WR_DATA, DONE.
- IDLE: cs_n low (cs_q high→low) → HDR, bit counter 0, shift cleared.
- HDR: on each sclk rise shift mosi in; after 1+ADDR_W bits latch reg_addr; R/W=1 → RD_WAIT with reg_rd_req=1; R/W=0 → WR_DATA.
- RD_WAIT: on reg_rd_ack, load tx shift with reg_rd_data, drop reg_rd_req next cycle, → RD_DATA. A sclk rise in RD_WAIT pulses err_late, drops req, tx shift loaded with zeros, → RD_DATA (counted as bit 0).
- RD_DATA: miso = tx MSB; shift left on sclk fall; count rises; after DATA_W rises → DONE.
- WR_DATA: shift mosi on rise; on DATA_W-th rise latch reg_wdata, → DONE; reg_we pulses in the following cycle.
- DONE: ignore further SCLK edges; cs_n high → IDLE.
- cs_n high in HDR, RD_WAIT, RD_DATA or WR_DATA → IDLE, err_abort pulse, no reg_we, reg_rd_req dropped.
- ena low: no state, edge or counter update; reg_we/err pulses still last exactly one clk.

## Timing
- Reset values: miso 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_rd_req 0, busy 0, err_abort 0, err_late 0, state IDLE.
- Edge detect latency: 1 clk after synchronized pin change.
- reg_rd_req asserts 1 clk after last header rise; ack same cycle as req permitted.
- miso valid 1 clk after ack; 0 outside RD_DATA.
- reg_we: 1 clk after last data rise, 1 clk wide.
- Simultaneous cs_n rise and last data rise: abort wins, no write.
- Simultaneous ack and sclk rise in RD_WAIT: ack wins, no err_late.
- Back-to-back frames need cs_n high for ≥1 enabled clk.

## Structure
- Package spi_frame_pkg: state enum, header R/W bit position constant, counter width = $clog2(1+ADDR_W+DATA_W+1).
- One sub-module: spi_edge_sync (sclk/cs edge history and rise/fall pulses with ena).

## Test plan
- Write frame 0x05/0xA5 (header 0_0000101) → one reg_we pulse, reg_addr=0x05, reg_wdata=0xA5.
- Read frame addr 0x12, ack 2 clk after req with 0x3C → miso bits 0,0,1,1,1,1,0,0, no err.
- Read with no ack before first data rise → err_late pulse, miso all 0, req dropped.
- cs_n high after 4 data bits of write → err_abort pulse, no reg_we, busy 0 next clk.
- 20 SCLK pulses in one write frame → single reg_we, extra edges ignored in DONE.
- rstb low mid-read (req high) → next clk all outputs at reset values, state IDLE.
